// File: rtl/sp_ram_multimode_if.sv
// Access bus for sp_ram_multimode: request fields driven by the master,
// read data, valid pulse and busy flag returned by the RAM.
interface sp_ram_multimode_if #(
    parameter int MEM_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_W     = 8
);
    localparam int NB = MEM_WIDTH / BYTE_W;

    logic                  en;
    logic                  we;
    logic [NB-1:0]         be;
    logic [1:0]            mode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [MEM_WIDTH-1:0]  din;
    logic [MEM_WIDTH-1:0]  dout;
    logic                  dout_valid;
    logic                  busy;

    modport master (
        output en, we, be, mode, addr, din,
        input  dout, dout_valid, busy
    );

    modport slave (
        input  en, we, be, mode, addr, din,
        output dout, dout_valid, busy
    );
endinterface

// File: rtl/sp_ram_multimode.sv
// Single-port synchronous RAM with per-access read-first / write-first / no-change
// mode, byte-lane write enables, optional output register and post-reset clear.
module sp_ram_multimode #(
    parameter int MEM_WIDTH  = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_W     = 8,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input logic              clk,
    input logic              rst,
    sp_ram_multimode_if.slave bus
);
    localparam int NB    = MEM_WIDTH / BYTE_W;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (MEM_WIDTH % BYTE_W != 0) begin : g_width_chk
        $error("sp_ram_multimode: MEM_WIDTH must be a multiple of BYTE_W");
    end

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  busy_q;

    logic [MEM_WIDTH-1:0]  mem [DEPTH];
    logic [MEM_WIDTH-1:0]  old_word;
    logic [MEM_WIDTH-1:0]  merged;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [MEM_WIDTH-1:0]  wr_data;
    logic                  access;

    logic [MEM_WIDTH-1:0]  dout1;
    logic                  valid1;

    assign old_word = mem[bus.addr];
    assign access   = (state == READY) && bus.en;

    // Lane merge is shared by the memory write and the write-first output.
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign merged[i*BYTE_W +: BYTE_W] = bus.be[i] ? bus.din[i*BYTE_W +: BYTE_W]
                                                      : old_word[i*BYTE_W +: BYTE_W];
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = bus.addr;
        wr_data = merged;
        if (!rst) begin
            if (state == CLEAR) begin
                wr_en   = 1'b1;
                wr_addr = cnt;
                wr_data = '0;
            end else if (bus.en && bus.we) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= (INIT_CLEAR != 0) ? CLEAR : READY;
            cnt    <= '0;
            busy_q <= (INIT_CLEAR != 0);
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == '1) begin
                        state  <= READY;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= READY;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // No-change writes and idle cycles hold dout and drop valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout1  <= '0;
            valid1 <= 1'b0;
        end else if (access && !(bus.we && bus.mode == 2'b10)) begin
            dout1  <= (bus.we && bus.mode == 2'b01) ? merged : old_word;
            valid1 <= 1'b1;
        end else begin
            valid1 <= 1'b0;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [MEM_WIDTH-1:0] dout2;
        logic                 valid2;
        always_ff @(posedge clk) begin
            if (rst) begin
                dout2  <= '0;
                valid2 <= 1'b0;
            end else begin
                dout2  <= dout1;
                valid2 <= valid1;
            end
        end
        assign bus.dout       = dout2;
        assign bus.dout_valid = valid2;
    end else begin : g_noreg
        assign bus.dout       = dout1;
        assign bus.dout_valid = valid1;
    end

    assign bus.busy = busy_q;
endmodule
